// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared types and constants for the sequential digit multiplier
package mul_seq_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam int DIGIT_W = 4;

    // Number of digit-pair iterations for a w-bit operand pair
    function automatic int k_of(input int w);
        return (w / DIGIT_W) * (w / DIGIT_W);
    endfunction

endpackage

// File: rtl/mul_seq_ctrl_wallece_tree_4x4.sv
// wallece_tree_4x4: combinational 4x4 unsigned multiplier, two 3:2 compressor levels plus a final adder
module wallece_tree_4x4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    logic [7:0] r0, r1, r2, r3, s1, c1, s2, c2;

    // Reduce four shifted partial-product rows to sum/carry, then resolve
    always_comb begin
        r0 = {4'b0, a & {4{b[0]}}};
        r1 = {3'b0, a & {4{b[1]}}, 1'b0};
        r2 = {2'b0, a & {4{b[2]}}, 2'b0};
        r3 = {1'b0, a & {4{b[3]}}, 3'b0};
        s1 = r0 ^ r1 ^ r2;
        c1 = ((r0 & r1) | (r0 & r2) | (r1 & r2)) << 1;
        s2 = s1 ^ c1 ^ r3;
        c2 = ((s1 & c1) | (s1 & r3) | (c1 & r3)) << 1;
        p  = s2 + c2;
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: iterative WxW multiplier stepping digit pairs through one shared 4x4 tree
module mul_seq_ctrl
    import mul_seq_pkg::*;
#(
    parameter int W          = 8,
    parameter bit EARLY_ZERO = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_prod,
    output logic           busy
);

    localparam int D  = W / DIGIT_W;
    localparam int K  = k_of(W);
    localparam int IW = $clog2(K);

    state_t               state, state_nx, start_st;
    logic [W-1:0]         a_r, b_r;
    logic [2*W-1:0]       acc, term;
    logic [IW-1:0]        k, i_d, j_d;
    logic [DIGIT_W-1:0]   a_dig, b_dig;
    logic [7:0]           pp;
    logic                 accept, zero_in, last;

    assign accept   = in_valid && in_ready;
    assign zero_in  = EARLY_ZERO && (in_a == '0 || in_b == '0);
    assign start_st = zero_in ? DONE : CALC;
    assign last     = k == IW'(K - 1);
    // A digit is the inner loop, B digit the outer
    assign i_d      = IW'(k % D);
    assign j_d      = IW'(k / D);
    assign a_dig    = a_r[DIGIT_W*i_d +: DIGIT_W];
    assign b_dig    = b_r[DIGIT_W*j_d +: DIGIT_W];
    assign term     = {{(2*W-8){1'b0}}, pp} << {i_d + j_d, 2'b00};
    assign out_prod = acc;

    wallece_tree_4x4 u_tree (
        .a (a_dig),
        .b (b_dig),
        .p (pp)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: zero operands may skip straight to DONE; a DONE transfer can chain a new accept
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = accept ? start_st : IDLE;
            CALC:    state_nx = last ? DONE : CALC;
            DONE:    state_nx = out_ready ? (in_valid ? start_st : IDLE) : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        in_ready  = (state == IDLE) || (state == DONE && out_ready);
        out_valid = state == DONE;
        busy      = state == CALC;
    end

    // Operand capture on accept, shift-accumulate one digit pair per CALC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r <= '0;
            b_r <= '0;
            acc <= '0;
            k   <= '0;
        end else if (accept) begin
            a_r <= in_a;
            b_r <= in_b;
            acc <= '0;
            k   <= '0;
        end else if (state == CALC) begin
            acc <= acc + term;
            k   <= k + IW'(1);
        end
    end

endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Iterative unsigned W×W multiplier controller built around a single shared 4×4 Wallace tree multiplier.
- Splits each operand into 4-bit digits and steps through all digit pairs, one per cycle, shift-accumulating the 8-bit partial products into a 2W-bit accumulator.
- Presents valid/ready handshakes on the operand and result sides.
- Used wherever a wide product is needed at low area and multi-cycle latency is acceptable.

Parameters:
- W, 8, operand width in bits; must be a multiple of 4, legal range 8..16.
- EARLY_ZERO, 1, when 1 a zero operand bypasses iteration and produces the result one edge after acceptance.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands this cycle
- in_a  in  W  multiplicand, unsigned
- in_b  in  W  multiplier, unsigned
- out_valid  out  1  out_prod holds a completed product
- out_ready  in  1  consumer accepts product this cycle
- out_prod  out  2W  product in_a*in_b
- busy  out  1  high while iterating (CALC state)

Behaviour:
- Derived constants: D = W/4 digits per operand; K = D*D iterations (4 for W=8, 16 for W=16).
- FSM states: IDLE, CALC, DONE.
- Reset (async, rst_n low): state IDLE; accumulator 0; digit index 0; operand registers 0. Outputs: out_valid=0, out_prod=0, busy=0, in_ready=1 once rst_n is released.
- in_ready = (state==IDLE) || (state==DONE && out_ready). It is combinational from state and out_ready only, never from in_valid.
- Accept = in_valid && in_ready at a rising edge. On accept:
  - in_a/in_b are latched, the accumulator is cleared, and the index is set to 0.
  - Next state is CALC.
  - With EARLY_ZERO=1 and either operand zero, next state is DONE with the accumulator 0.
- Each CALC edge, index k in 0..K-1:
  - i = k mod D (A digit), j = k div D (B digit); B digit is the outer loop, A digit the inner.
  - acc <= acc + (A[4i+3:4i] * B[4j+3:4j]) << 4(i+j). The multiply uses the 4×4 tree; the add is 2W bits wide.
  - The accumulator never exceeds 2W bits: every partial sum is bounded by the final product.
  - k increments. On the edge where k==K-1, next state is DONE.
- Latency: out_valid rises exactly K edges after the accepting edge (1 edge on the EARLY_ZERO path).
- DONE: out_valid=1 and out_prod=acc, held stable while out_ready=0 (backpressure; in_ready=0 in that case).
- out_valid && out_ready at an edge completes the transfer:
  - If in_valid is also high that edge, the new operands are accepted and the next state is CALC (or DONE via EARLY_ZERO). This gives back-to-back throughput of one product per K+1 cycles.
  - Otherwise the next state is IDLE.
- out_prod retains its last value in IDLE; it is only meaningful while out_valid is high.
- busy = (state==CALC).
- in_valid and operand changes during CALC are ignored; the latched operands are used.
- rst_n asserted mid-CALC or in DONE: immediate return to the reset state, partial result discarded, no out_valid pulse.
- in_valid must be held until accepted; in_a/in_b must be stable while in_valid && !in_ready (protocol rule, checked by assertion).

Decomposition:
- Package mul_seq_pkg:
  - state enum {IDLE, CALC, DONE}
  - DIGIT_W=4
  - function computing K from W
- Sub-module: exactly one, the existing wallece_tree_4x4, instantiated once and fed by digit muxes selected by i and j.
- The controller owns the FSM, the index counter, the operand registers, the shift and the accumulator.

Test Plan:
- W=8, in_a=8'hFF, in_b=8'hFF, out_ready=1 → out_prod=16'hFE01, out_valid high 4 edges after accept, busy high exactly 4 cycles.
- W=8, in_a=8'h00, in_b=8'h5A, EARLY_ZERO=1 → out_prod=16'h0000 one edge after accept; with EARLY_ZERO=0, same result after 4 edges.
- W=8, in_a=8'h3C, in_b=8'hA7, out_ready=0 for 10 cycles → out_valid stays high, out_prod=16'h2724 stable, in_ready=0; when out_ready rises, one transfer occurs and the FSM returns to IDLE.
- Back-to-back with in_valid continuously high and out_ready=1, pairs (8'h12,8'h34), (8'hFF,8'h01) → products 16'h03A8 then 16'h00FF, with the second accept on the same edge as the first result transfer.
- rst_n pulsed low during the 2nd CALC cycle of 8'hAB*8'hCD → out_valid, busy and out_prod go to 0 asynchronously; the next operation 8'h02*8'h03 yields 16'h0006.
- W=16, in_a=16'hFFFF, in_b=16'hFFFF → out_prod=32'hFFFE0001, latency 16 edges.
